uart_tx_buffer: RTL
===================

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, 2..256.
REQ-002 SHALL have parameter START_TO, default 15, max cycles to wait for is_transmitting to rise after a transmit pulse.
REQ-003 SHALL have parameter LOW_WATER, default 2, threshold for tx_irq.
REQ-004 clk  in  1  sole clock; all logic on posedge clk.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 wr_en  in  1  one-cycle push strobe from the core store decode.
REQ-007 wr_data  in  8  byte to enqueue.
REQ-008 is_transmitting  in  1  UART serializer busy flag.
REQ-009 transmit  out  1  one-cycle start pulse to the UART.
REQ-010 tx_byte  out  8  byte presented to the UART; held stable from transmit until the state machine returns to IDLE.
REQ-011 full  out  1  FIFO holds DEPTH entries.
REQ-012 empty  out  1  FIFO holds 0 entries.
REQ-013 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-014 wr_err  out  1  one-cycle pulse when a push is dropped.
REQ-015 drop  out  1  one-cycle pulse on start timeout.
REQ-016 busy  out  1  high whenever the state machine is not IDLE.

Function
REQ-017 FIFO SHALL be circular with wr_ptr/rd_ptr wrapping from DEPTH-1 to 0; count SHALL be registered.
REQ-018 Push SHALL occur when wr_en=1 and (full=0 or a pop occurs in the same cycle).
REQ-019 A push with full=1 and no same-cycle pop SHALL be dropped, pulse wr_err the next cycle, and leave the FIFO unchanged.
REQ-020 Simultaneous push and pop SHALL leave count unchanged.
REQ-021 States SHALL be IDLE, LOAD, WAIT_START and WAIT_DONE.
REQ-022 IDLE -> LOAD SHALL occur when empty=0 and is_transmitting=0; this cycle pops the FIFO and registers tx_byte <= head.
REQ-023 In LOAD, transmit SHALL be 1 for exactly that cycle; next state SHALL be WAIT_START with timeout counter cleared.
REQ-024 In WAIT_START, is_transmitting=1 SHALL move to WAIT_DONE.
REQ-025 After START_TO cycles in WAIT_START without is_transmitting, the block SHALL pulse drop for one cycle and return to IDLE; the byte is discarded.
REQ-026 In WAIT_DONE, is_transmitting=0 SHALL move to IDLE.
REQ-027 Minimum spacing between transmit pulses SHALL be 4 cycles (LOAD, WAIT_START, WAIT_DONE, IDLE).
REQ-028 A push into an empty FIFO SHALL produce transmit no earlier than 2 cycles after wr_en.

Reset
REQ-029 rst=1 SHALL force state IDLE, pointers 0, count=0, empty=1, full=0, transmit=0, tx_byte=0, wr_err=0, drop=0, busy=0.
REQ-030 rst=1 mid-transfer SHALL abandon the transfer and discard FIFO contents; rst has priority over wr_en.
REQ-031 Memory contents SHALL NOT require reset.

Configuration
REQ-032 Macro UART_TX_IRQ_EN SHALL, when defined, add output tx_irq (1 bit), registered, equal to (count <= LOW_WATER), reset value 1.
REQ-033 Without UART_TX_IRQ_EN, the tx_irq port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-034 Package uart_tx_pkg SHALL hold the state enum type (tx_state_t) and the default DEPTH, START_TO and LOW_WATER constants.
REQ-035 Storage and pointers SHALL live in sub-module tx_sync_fifo; the state machine stays in uart_tx_buffer.

Verification
REQ-036 Push 0x55 into an empty FIFO; model the UART to raise is_transmitting 1 cycle after transmit for 10 cycles -> exactly one transmit, tx_byte=0x55, busy falls after is_transmitting falls, count returns to 0.
REQ-037 Push 17 bytes 0x00..0x10 back-to-back (DEPTH=16) with is_transmitting held high -> count=16, full=1, one wr_err on the 17th push, FIFO contents unchanged.
REQ-038 Fill FIFO, then push while a pop occurs -> push accepted, count stays 16, no wr_err.
REQ-039 Push 0xA5 and never assert is_transmitting -> drop pulses 16 cycles after transmit (START_TO=15), state returns to IDLE, empty=1.
REQ-040 Assert rst in WAIT_DONE with 5 bytes queued -> next cycle count=0, empty=1, busy=0, and no transmit follows.
REQ-041 With UART_TX_IRQ_EN and LOW_WATER=2, push 3 bytes, then drain -> tx_irq=0 while count=3, and 1 once count<=2.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and default parameters for the UART transmit buffer.
package uart_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD       = 2'd1,
    ST_WAIT_START = 2'd2,
    ST_WAIT_DONE  = 2'd3
  } tx_state_t;

  localparam int DEF_DEPTH     = 16;
  localparam int DEF_START_TO  = 15;
  localparam int DEF_LOW_WATER = 2;

endpackage

// File: rtl/tx_sync_fifo.sv
// Circular byte FIFO with registered occupancy; a push into a full FIFO is
// accepted only when a pop happens in the same cycle, otherwise wr_err pulses.
module tx_sync_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Reset outranks any push, so a write during rst never lands in memory.
  assign pop  = rd_en && !empty;
  assign push = !rst && wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // DEPTH is a power of two, so pointer overflow is the DEPTH-1 -> 0 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      wr_err <= wr_en && full && !pop;
    end
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte queue feeding a UART serializer with start-timeout recovery.
// Optional macro UART_TX_IRQ_EN adds the registered low-water tx_irq output.
module uart_tx_buffer
  import uart_tx_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int START_TO  = DEF_START_TO,
  parameter int LOW_WATER = DEF_LOW_WATER
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   is_transmitting,
  output logic                   transmit,
  output logic [7:0]             tx_byte,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   wr_err,
  output logic                   drop,
  output logic                   busy,
`ifdef UART_TX_IRQ_EN
  output logic                   tx_irq,
`endif
  output tx_state_t              state_dbg
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(START_TO + 1);

  tx_state_t     state;
  tx_state_t     state_nxt;
  logic [TW-1:0] timer;
  logic          pop_req;
  logic          timeout;
  logic [7:0]    head;

  tx_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop_req),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .wr_err  (wr_err)
  );

  // UART handshake: transmit is a one-cycle request; the serializer accepts
  // by raising is_transmitting and completes by dropping it. A request with
  // no acceptance within START_TO cycles is abandoned and reported via drop.
  always_comb begin
    state_nxt = state;
    pop_req   = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && !is_transmitting) begin
          state_nxt = ST_LOAD;
          pop_req   = 1'b1;
        end
      end
      ST_LOAD: state_nxt = ST_WAIT_START;
      ST_WAIT_START: begin
        if (is_transmitting) begin
          state_nxt = ST_WAIT_DONE;
        end else if (timer == TW'(START_TO - 1)) begin
          state_nxt = ST_IDLE;
          timeout   = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!is_transmitting) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx_byte <= '0;
      timer   <= '0;
      drop    <= 1'b0;
    end else begin
      state <= state_nxt;
      drop  <= timeout;
      if (pop_req) tx_byte <= head;
      if (state == ST_LOAD)            timer <= '0;
      else if (state == ST_WAIT_START) timer <= timer + TW'(1);
    end
  end

  assign transmit  = (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

`ifdef UART_TX_IRQ_EN
  // Registered from next-cycle occupancy so tx_irq lines up with count.
  logic          push_acc;
  logic [CW-1:0] count_nxt;

  always_comb begin
    push_acc  = wr_en && (!full || pop_req);
    count_nxt = count;
    if (push_acc && !pop_req)      count_nxt = count + CW'(1);
    else if (pop_req && !push_acc) count_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) tx_irq <= 1'b1;
    else     tx_irq <= (count_nxt <= CW'(LOW_WATER));
  end
`endif

endmodule
